patch_bus_driver: RTL
=====================

# patch_bus_driver

Downstream consumer of `patch_store`: tracks DSi RAM bursts in the `mclk` domain and, when a read burst has been patched, drives the patch words onto the RAM data bus in place of the real RAM. It takes `patch_trigger` and `patch_data` from `patch_store` and returns `patch_data_next` once per word consumed by the host. It outputs `ram_dq_out` and `ram_dq_oe` to the top-level tristate pads.

## Interface
- `LATENCY`, 4: RAM clock rising edges from the address edge to the first data sample edge. Legal range is 2..15.
- `MAX_WORDS`, 64: maximum words driven per burst. The bus is released after this many words.
- `mclk` input 1: master clock.
- `reset` input 1: asynchronous, active-high.
- `ram_clk` input 1: raw RAM clock, asynchronous to `mclk`.
- `ram_ce_n` input 1: raw RAM chip enable, active-low.
- `ram_adv_n` input 1: raw address valid, active-low.
- `ram_we_n` input 1: raw write enable, active-low.
- `patch_trigger` input 1: one-`mclk` pulse from `patch_store`; the current burst is patched.
- `patch_data` input 16: current patch word from `patch_store`.
- `patch_data_next` output 1: one-`mclk` pulse asking `patch_store` to advance to the next word.
- `ram_dq_out` output 16: data to be driven onto the RAM bus.
- `ram_dq_oe` output 1: pad output enable, active-high.
- `patch_active` output 1: high while state is ARMED or DRIVE.
- `patch_count` output 16: number of patched read bursts, saturating at 16'hFFFF.

## Operation
- **Synchronizers.** `ram_clk`, `ram_ce_n`, `ram_adv_n` and `ram_we_n` each pass through flops s1→s2. `ram_clk` has a third flop s3.
  - `rise` = s2 & ~s3.
  - `fall` = ~s2 & s3.
  - Control signals are taken from their s2 values.
- **Address edge.** `rise` with ce_n=0 and adv_n=0.
  - Clears `edge_cnt` (4-bit) and `word_cnt` (7-bit).
  - Latches `is_write` = ~we_n.
  - Enters WAIT_TRIG from any state. A new address edge aborts the current burst: `ram_dq_oe` drops on that cycle.
- **`edge_cnt`.** Increments on every `rise` that is not an address edge, and saturates at 15.
- **States.**
  - **IDLE:** `ram_dq_oe`=0. `patch_trigger` is ignored.
  - **WAIT_TRIG:**
    - `patch_trigger` with `is_write`=0 → ARMED, and `patch_count` increments (saturating).
    - `patch_trigger` with `is_write`=1 → IDLE.
    - `edge_cnt` reaching LATENCY-1 with no trigger → IDLE. The burst is not patched and the real RAM answers.
  - **ARMED:** on the first `fall` after `edge_cnt` ≥ LATENCY-1:
    - `ram_dq_out` ← `patch_data`;
    - `ram_dq_oe` ← 1;
    - go to DRIVE.
  - **DRIVE:**
    - Each `rise` counts as a host sample: `word_cnt`++ and `patch_data_next` pulses for 1 cycle.
    - Each following `fall` loads `ram_dq_out` ← `patch_data`.
    - When `word_cnt` reaches MAX_WORDS → IDLE with `ram_dq_oe`=0. The `patch_data_next` for that final sample still pulses.
- **End of burst.** Synchronized ce_n=1 in any state → IDLE, with `ram_dq_oe`=0 on the same cycle. No `patch_data_next` is issued on that cycle.
- **Simultaneous events.**
  - ce_n=1 takes priority over `rise`/`fall`.
  - An address edge takes priority over a trigger in the same cycle; that trigger is dropped.
- **`ram_dq_out`.** Holds its last value when `ram_dq_oe`=0.

## Timing
- **Reset values.**
  - State: IDLE.
  - `ram_dq_oe`=0, `ram_dq_out`=0, `patch_data_next`=0.
  - `patch_active`=0, `patch_count`=0.
  - All synchronizer flops 1, except `ram_clk` flops 0.
  - Reset mid-burst releases the bus immediately (asynchronously).
- **Edge detect latency.** A raw `ram_clk` edge appears as `rise`/`fall` 3 `mclk` later, ±1 for metastability.
- **Trigger window.** `patch_trigger` must arrive before the LATENCY-1th counted `rise`. `patch_store` delivers it about 4 `mclk` after the address strobe, which is well inside the window at ≥12 `mclk` per RAM clock.
- **Word update.** `patch_store` has until the next `fall`, about ½ RAM clock, to update `patch_data` after `patch_data_next`.
- **Output registration.** All outputs are registered; no combinational path runs from inputs to outputs.

## Test plan
1. **Patched read.**
   - Stimulus: `ram_clk` period 24 `mclk`, LATENCY=4. Read burst: address edge, `patch_trigger` 4 `mclk` later, `patch_data` sequence 16'h1111, 2222, 3333, 4 words, then ce_n=1.
   - Required response:
     - `ram_dq_oe` rises at the `fall` after edge 3.
     - `ram_dq_out` shows 1111/2222/3333/… sampled at edges 4, 5, 6, …
     - exactly 4 `patch_data_next` pulses;
     - `patch_count`=1.
2. **No trigger.** Read burst without `patch_trigger` → `ram_dq_oe` stays 0, no `patch_data_next`, `patch_count` stays 0.
3. **Write burst.** Write burst (we_n=0) with `patch_trigger` → `ram_dq_oe` stays 0, `patch_count` unchanged.
4. **Length limit and counter saturation.**
   - MAX_WORDS=4, host clocks 10 words → oe drops after the 4th sample edge, exactly 4 `patch_data_next` pulses.
   - Preload `patch_count`=16'hFFFF via 65535 bursts (or force) → it stays 16'hFFFF.
5. **Aborts.**
   - New address edge during DRIVE → oe drops the same cycle, state is WAIT_TRIG, `word_cnt`=0.
   - Trigger coincident with an address edge → dropped.
6. **Reset mid-burst.** Assert `reset` in DRIVE → `ram_dq_oe`=0 asynchronously. After release, the next patched burst behaves as in scenario 1.

Source files
------------

// File: rtl/patch_bus_driver.sv
// patch_bus_driver: follows DSi RAM bursts in the mclk domain and, when
// patch_store flags a read burst as patched, drives the patch words onto the
// RAM data bus in place of the real RAM.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// IDLE      | bus released; patch_trigger ignored
// WAIT_TRIG | address edge seen; waiting for patch_trigger or the timeout
// ARMED     | patched read; waiting for the fall before the first sample
// DRIVE     | driving patch words; one word per host sample edge
module patch_bus_driver #(
  parameter int unsigned LATENCY   = 4,
  parameter int unsigned MAX_WORDS = 64
) (
  input  logic        mclk,
  input  logic        reset,
  input  logic        ram_clk,
  input  logic        ram_ce_n,
  input  logic        ram_adv_n,
  input  logic        ram_we_n,
  input  logic        patch_trigger,
  input  logic [15:0] patch_data,
  output logic        patch_data_next,
  output logic [15:0] ram_dq_out,
  output logic        ram_dq_oe,
  output logic        patch_active,
  output logic [15:0] patch_count
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_TRIG = 2'd1,
    ARMED     = 2'd2,
    DRIVE     = 2'd3
  } state_t;

  // Edge index (counted after the address edge) whose fall starts driving.
  localparam logic [3:0] EDGE_ARM   = 4'(LATENCY - 1);
  localparam logic [6:0] WORD_LIMIT = 7'(MAX_WORDS);

  // ram_clk gets a third stage so both edges can be detected from s2/s3.
  logic [2:0]  clk_sync_q, clk_sync_d;
  logic [1:0]  ce_sync_q,  ce_sync_d;
  logic [1:0]  adv_sync_q, adv_sync_d;
  logic [1:0]  we_sync_q,  we_sync_d;

  state_t      state_q, state_d;
  logic [3:0]  edge_cnt_q, edge_cnt_d;
  logic [6:0]  word_cnt_q, word_cnt_d;
  logic        is_write_q, is_write_d;
  logic [15:0] dq_out_q, dq_out_d;
  logic        dq_oe_q, dq_oe_d;
  logic        data_next_q, data_next_d;
  logic        patch_active_q, patch_active_d;
  logic [15:0] patch_count_q, patch_count_d;

  logic rise;
  logic fall;
  logic ce_n_s;
  logic adv_n_s;
  logic we_n_s;
  logic addr_edge;

  // Shift each raw RAM signal one stage further down its synchronizer.
  always_comb begin
    clk_sync_d = {clk_sync_q[1:0], ram_clk};
    ce_sync_d  = {ce_sync_q[0],  ram_ce_n};
    adv_sync_d = {adv_sync_q[0], ram_adv_n};
    we_sync_d  = {we_sync_q[0],  ram_we_n};
  end

  // Synchronizer flops: RAM clock idles low, active-low controls idle high.
  always_ff @(posedge mclk or posedge reset) begin
    if (reset) begin
      clk_sync_q <= 3'b000;
      ce_sync_q  <= 2'b11;
      adv_sync_q <= 2'b11;
      we_sync_q  <= 2'b11;
    end else begin
      clk_sync_q <= clk_sync_d;
      ce_sync_q  <= ce_sync_d;
      adv_sync_q <= adv_sync_d;
      we_sync_q  <= we_sync_d;
    end
  end

  assign rise      = clk_sync_q[1] & ~clk_sync_q[2];
  assign fall      = ~clk_sync_q[1] & clk_sync_q[2];
  assign ce_n_s    = ce_sync_q[1];
  assign adv_n_s   = adv_sync_q[1];
  assign we_n_s    = we_sync_q[1];
  assign addr_edge = rise & ~ce_n_s & ~adv_n_s;

  // Next-state, counters and bus outputs; end of burst beats address edge,
  // which beats anything the current state wants to do.
  always_comb begin
    state_d        = state_q;
    edge_cnt_d     = edge_cnt_q;
    word_cnt_d     = word_cnt_q;
    is_write_d     = is_write_q;
    dq_out_d       = dq_out_q;
    dq_oe_d        = dq_oe_q;
    data_next_d    = 1'b0;
    patch_count_d  = patch_count_q;

    if (rise && !addr_edge && (edge_cnt_q != 4'hF)) begin
      edge_cnt_d = edge_cnt_q + 4'd1;
    end

    if (ce_n_s) begin
      state_d = IDLE;
      dq_oe_d = 1'b0;
    end else if (addr_edge) begin
      state_d    = WAIT_TRIG;
      dq_oe_d    = 1'b0;
      edge_cnt_d = 4'd0;
      word_cnt_d = 7'd0;
      is_write_d = ~we_n_s;
    end else begin
      unique case (state_q)
        IDLE: begin
          dq_oe_d = 1'b0;
        end
        WAIT_TRIG: begin
          if (patch_trigger) begin
            if (!is_write_q) begin
              state_d = ARMED;
              if (patch_count_q != 16'hFFFF) begin
                patch_count_d = patch_count_q + 16'd1;
              end
            end else begin
              state_d = IDLE;
            end
          end else if (edge_cnt_q >= EDGE_ARM) begin
            // Too late to patch: let the real RAM answer this burst.
            state_d = IDLE;
          end
        end
        ARMED: begin
          if (fall && (edge_cnt_q >= EDGE_ARM)) begin
            dq_out_d = patch_data;
            dq_oe_d  = 1'b1;
            state_d  = DRIVE;
          end
        end
        DRIVE: begin
          if (rise) begin
            word_cnt_d  = word_cnt_q + 7'd1;
            data_next_d = 1'b1;
            if ((word_cnt_q + 7'd1) >= WORD_LIMIT) begin
              state_d = IDLE;
              dq_oe_d = 1'b0;
            end
          end else if (fall) begin
            dq_out_d = patch_data;
          end
        end
        default: begin
          state_d = IDLE;
          dq_oe_d = 1'b0;
        end
      endcase
    end

    patch_active_d = (state_d == ARMED) || (state_d == DRIVE);
  end

  // State, counters and registered outputs; reset drops the bus at once.
  always_ff @(posedge mclk or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      edge_cnt_q     <= 4'd0;
      word_cnt_q     <= 7'd0;
      is_write_q     <= 1'b0;
      dq_out_q       <= 16'h0000;
      dq_oe_q        <= 1'b0;
      data_next_q    <= 1'b0;
      patch_active_q <= 1'b0;
      patch_count_q  <= 16'h0000;
    end else begin
      state_q        <= state_d;
      edge_cnt_q     <= edge_cnt_d;
      word_cnt_q     <= word_cnt_d;
      is_write_q     <= is_write_d;
      dq_out_q       <= dq_out_d;
      dq_oe_q        <= dq_oe_d;
      data_next_q    <= data_next_d;
      patch_active_q <= patch_active_d;
      patch_count_q  <= patch_count_d;
    end
  end

  assign patch_data_next = data_next_q;
  assign ram_dq_out      = dq_out_q;
  assign ram_dq_oe       = dq_oe_q;
  assign patch_active    = patch_active_q;
  assign patch_count     = patch_count_q;

endmodule
